// File: rtl/score_display.sv
// Two-number seven-segment scanner: step count and elapsed time,
// converted to BCD by a shared sequential double-dabble engine.
module score_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk_d,
  input  logic       rst,
  input  logic [7:0] step_number,
  input  logic [7:0] game_time,
  output logic [7:0] DIG,
  output logic [7:0] Y
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic [19:0] TC = 20'(SCAN_DIV - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic [7:0]  op_q, op_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  s_h_q, s_h_d, s_t_q, s_t_d, s_o_q, s_o_d;
  logic [3:0]  t_h_q, t_h_d, t_t_q, t_t_d, t_o_q, t_o_d;
  logic [19:0] pre_q, pre_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  dig_q, dig_d;
  logic [7:0]  y_q, y_d;
  logic [11:0] adj;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [7:0] seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'd0: s = 8'hC0;
      4'd1: s = 8'hF9;
      4'd2: s = 8'hA4;
      4'd3: s = 8'hB0;
      4'd4: s = 8'h99;
      4'd5: s = 8'h92;
      4'd6: s = 8'h82;
      4'd7: s = 8'hF8;
      4'd8: s = 8'h80;
      4'd9: s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Converter: load operand, 8 shift-add-3 steps, commit to selected source
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    op_d    = op_q;
    bcd_d   = bcd_q;
    s_h_d   = s_h_q;
    s_t_d   = s_t_q;
    s_o_d   = s_o_q;
    t_h_d   = t_h_q;
    t_t_d   = t_t_q;
    t_o_d   = t_o_q;
    adj     = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    unique case (state_q)
      LOAD: begin
        op_d    = sel_q ? game_time : step_number;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, op_d} = {adj[10:0], op_q, 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = COMMIT;
      end
      COMMIT: begin
        if (sel_q) begin
          t_h_d = bcd_q[11:8];
          t_t_d = bcd_q[7:4];
          t_o_d = bcd_q[3:0];
        end else begin
          s_h_d = bcd_q[11:8];
          s_t_d = bcd_q[7:4];
          s_o_d = bcd_q[3:0];
        end
        sel_d   = ~sel_q;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Scan prescaler, digit index and registered digit/segment drive
  always_comb begin
    pre_d = pre_q + 20'd1;
    idx_d = idx_q;
    if (pre_q == TC) begin
      pre_d = '0;
      idx_d = idx_q + 3'd1;
    end
    dig_d = ~(8'h01 << idx_q);
    y_d   = 8'hFF;
    case (idx_q)
      3'd7: y_d = (s_h_q == 4'd0) ? 8'hFF : seg(s_h_q);
      3'd6: y_d = (s_h_q == 4'd0 && s_t_q == 4'd0) ? 8'hFF : seg(s_t_q);
      3'd5: y_d = seg(s_o_q);
      3'd4: y_d = 8'hFF;
      3'd3: y_d = 8'hBF;
      3'd2: y_d = (t_h_q == 4'd0) ? 8'hFF : seg(t_h_q);
      3'd1: y_d = (t_h_q == 4'd0 && t_t_q == 4'd0) ? 8'hFF : seg(t_t_q);
      default: y_d = seg(t_o_q);
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_d) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      op_q    <= '0;
      bcd_q   <= '0;
      s_h_q   <= '0;
      s_t_q   <= '0;
      s_o_q   <= '0;
      t_h_q   <= '0;
      t_t_q   <= '0;
      t_o_q   <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      dig_q   <= 8'hFF;
      y_q     <= 8'hFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      bcd_q   <= bcd_d;
      s_h_q   <= s_h_d;
      s_t_q   <= s_t_d;
      s_o_q   <= s_o_d;
      t_h_q   <= t_h_d;
      t_t_q   <= t_t_d;
      t_o_q   <= t_o_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      y_q     <= y_d;
    end
  end

  assign DIG = dig_q;
  assign Y   = y_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: reset, scan timing, conversion,
// boundary digits, mid-conversion input change and mid-run reset.
module tb_score_display;

  logic       clk_d = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] step_number = 8'd0;
  logic [7:0] game_time = 8'd0;
  logic [7:0] DIG;
  logic [7:0] Y;

  int vectors = 0;
  int miscompares = 0;

  score_display #(.SCAN_DIV(4)) dut (
    .clk_d(clk_d),
    .rst(rst),
    .step_number(step_number),
    .game_time(game_time),
    .DIG(DIG),
    .Y(Y)
  );

  always #5 clk_d = ~clk_d;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_step(input string tag, input logic [3:0] h,
                          input logic [3:0] t, input logic [3:0] o);
    chk({tag, "_step"}, {dut.s_h_q, dut.s_t_q, dut.s_o_q}, {h, t, o});
  endtask

  task automatic chk_time(input string tag, input logic [3:0] h,
                          input logic [3:0] t, input logic [3:0] o);
    chk({tag, "_time"}, {dut.t_h_q, dut.t_t_q, dut.t_o_q}, {h, t, o});
  endtask

  task automatic slot(input int idx, input logic [7:0] exp,
                      input string tag);
    logic [7:0] want;
    bit hit;
    want = ~(8'h01 << idx);
    hit = 0;
    for (int i = 0; i < 80 && !hit; i++) begin
      @(negedge clk_d);
      if (DIG === want) hit = 1;
    end
    chk({tag, "_dig"}, DIG, want);
    chk(tag, Y, exp);
  endtask

  task automatic wait_state(input logic [1:0] st, input logic sl,
                            input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk_d);
      if (dut.state_q === st && dut.sel_q === sl) hit = 1;
    end
    chk({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  initial begin
    logic [7:0] w;
    step_number = 8'd237;
    game_time   = 8'd5;
    rst = 1'b1;
    repeat (3) @(negedge clk_d);
    chk("rst_dig", DIG, 8'hFF);
    chk("rst_y", Y, 8'hFF);
    chk_step("rst", 4'd0, 4'd0, 4'd0);
    chk_time("rst", 4'd0, 4'd0, 4'd0);
    rst = 1'b0;

    // First edge out of reset and scan cadence
    for (int s = 0; s < 9; s++) begin
      for (int r = 0; r < 4; r++) begin
        @(negedge clk_d);
        w = ~(8'h01 << (s % 8));
        chk("scan_dig", DIG, w);
        chk("scan_onehot", $countones(~DIG), 1);
        if (s == 0 && r == 0) begin
          chk("first_y", Y, 8'hC0);
          chk_step("first", 4'd0, 4'd0, 4'd0);
          chk_time("first", 4'd0, 4'd0, 4'd0);
        end
        if (s == 4) chk("slot4_blank", Y, 8'hFF);
        if (s == 3) chk("slot3_dash", Y, 8'hBF);
      end
    end

    repeat (30) @(negedge clk_d);
    chk_step("c237", 4'd2, 4'd3, 4'd7);
    chk_time("c5", 4'd0, 4'd0, 4'd5);
    slot(7, 8'hA4, "c237_h");
    slot(6, 8'hB0, "c237_t");
    slot(5, 8'hF8, "c237_o");
    slot(2, 8'hFF, "c5_h");
    slot(1, 8'hFF, "c5_t");
    slot(0, 8'h92, "c5_o");

    step_number = 8'd255;
    repeat (30) @(negedge clk_d);
    slot(7, 8'hA4, "s255_h");
    slot(6, 8'h92, "s255_t");
    slot(5, 8'h92, "s255_o");

    step_number = 8'd0;
    repeat (30) @(negedge clk_d);
    slot(7, 8'hFF, "s0_h");
    slot(6, 8'hFF, "s0_t");
    slot(5, 8'hC0, "s0_o");

    step_number = 8'd100;
    repeat (30) @(negedge clk_d);
    slot(7, 8'hF9, "s100_h");
    slot(6, 8'hC0, "s100_t");
    slot(5, 8'hC0, "s100_o");

    game_time = 8'd9;
    repeat (30) @(negedge clk_d);
    slot(2, 8'hFF, "t9_h");
    slot(1, 8'hFF, "t9_t");
    slot(0, 8'h90, "t9_o");

    // Input changes while a step conversion is shifting
    step_number = 8'd12;
    wait_state(2'd0, 1'b0, "mid_load");
    @(negedge clk_d);
    chk("mid_in_shift", 32'(dut.state_q), 32'd1);
    step_number = 8'd99;
    wait_state(2'd2, 1'b0, "mid_commit");
    @(negedge clk_d);
    chk_step("mid_frozen", 4'd0, 4'd1, 4'd2);
    repeat (30) @(negedge clk_d);
    chk_step("mid_later", 4'd0, 4'd9, 4'd9);

    // Reset during a shift while 237 is on display
    step_number = 8'd237;
    repeat (30) @(negedge clk_d);
    chk_step("pre_rst", 4'd2, 4'd3, 4'd7);
    wait_state(2'd1, 1'b0, "rst_shift");
    rst = 1'b1;
    step_number = 8'd42;
    @(negedge clk_d);
    chk("mrst_dig", DIG, 8'hFF);
    chk("mrst_y", Y, 8'hFF);
    chk("mrst_pre", 32'(dut.pre_q), 32'd0);
    chk("mrst_idx", 32'(dut.idx_q), 32'd0);
    chk("mrst_fsm", 32'(dut.state_q), 32'd0);
    chk("mrst_sel", 32'(dut.sel_q), 32'd0);
    chk_step("mrst", 4'd0, 4'd0, 4'd0);
    chk_time("mrst", 4'd0, 4'd0, 4'd0);
    @(negedge clk_d);
    rst = 1'b0;
    @(negedge clk_d);
    chk("mrel_dig", DIG, 8'hFE);
    chk("mrel_y", Y, 8'hC0);
    repeat (30) @(negedge clk_d);
    chk_step("reconv", 4'd0, 4'd4, 4'd2);
    chk_time("reconv", 4'd0, 4'd0, 4'd9);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk_d cycles per digit scan slot; legal range 2..2^20.
REQ-002 SHALL have port clk_d  input  1  system clock; all state on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port step_number  input  8  move count, unsigned binary 0..255.
REQ-005 SHALL have port game_time  input  8  elapsed seconds, unsigned binary 0..255.
REQ-006 SHALL have port DIG  output  8  digit enables, active-low, one-hot-low; bit 7 is leftmost digit.
REQ-007 SHALL have port Y  output  8  segments, active-low, Y[7]=dp, Y[6:0]=g,f,e,d,c,b,a.

Function
REQ-008 SHALL use a single clock, clk_d, with synchronous active-high reset rst; no other clocks, no asynchronous logic.
REQ-009 SHALL convert binary to BCD sequentially with shift-add-3 (double dabble): one shift per cycle, never combinationally.
REQ-010 SHALL run converter FSM states LOAD -> SHIFT (exactly 8 cycles) -> COMMIT -> LOAD, continuously; each conversion is 10 cycles.
REQ-011 LOAD SHALL capture operand from source sel (0=step_number, 1=game_time) and clear the 12-bit BCD accumulator.
REQ-012 In each SHIFT cycle, before shifting, any BCD nibble >=5 SHALL have 3 added.
REQ-013 COMMIT SHALL write hundreds/tens/ones into the display register of source sel, then toggle sel.
REQ-014 Display registers SHALL change only in COMMIT; input changes mid-conversion SHALL NOT corrupt an in-flight conversion; the operand is frozen at LOAD.
REQ-015 A stable input value SHALL appear in its display register within 30 cycles of changing.
REQ-016 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; at terminal count the 3-bit scan index SHALL increment, wrapping 7->0.
REQ-017 Digit mapping by scan index SHALL be: 7=step hundreds, 6=step tens, 5=step ones, 4=blank, 3='-', 2=time hundreds, 1=time tens, 0=time ones.
REQ-018 A hundreds digit equal to 0 SHALL be blanked.
REQ-019 A tens digit SHALL be blanked when both hundreds and tens are 0.
REQ-020 Ones digits SHALL never be blanked, so 0 displays as "0".
REQ-021 Y encoding SHALL be:
- 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex);
- '-'=BF, blank=FF;
- dp always off (Y[7]=1).
REQ-022 DIG SHALL be registered and equal ~(8'h01 << scan index), delayed one cycle from the index.
REQ-023 Y SHALL be registered and decode the slot selected by the same index, delayed one cycle, so DIG and Y always change on the same edge.
REQ-024 DIG SHALL never have more than one bit low in any cycle.
REQ-025 BCD nibble values >9 SHALL be unreachable; the decoder SHALL output FF for them.

Reset
REQ-026 While rst=1 at a clock edge, the following SHALL hold:
- prescaler=0, scan index=0;
- FSM=LOAD, sel=0;
- all display registers=0;
- DIG=FF, Y=FF.
REQ-027 On the first edge after rst deasserts, DIG SHALL become FE and Y SHALL become C0 (time ones digit = 0).
REQ-028 A reset asserted mid-conversion or mid-scan SHALL abort it and restore the REQ-026 state on that same edge.

Verification
REQ-029 Reset: hold rst 3 cycles, then release -> DIG=FF, Y=FF during reset; next edge DIG=FE, Y=C0; display regs all 0.
REQ-030 Conversion: SCAN_DIV=4, step_number=8'd237, game_time=8'd5, wait 30 cycles -> step regs 2/3/7, time regs 0/0/5; time slots 2,1,0 emit FF, FF, 92.
REQ-031 Scan: SCAN_DIV=4 -> DIG steps FE, FD, FB, ... 7F, FE, each held exactly 4 cycles; never more than one bit low; slot 4 emits FF, slot 3 emits BF.
REQ-032 Boundary values:
- step_number=255 -> slots 7..5 emit A4, 92, 92;
- step_number=0 -> slots 7..5 emit FF, FF, C0;
- step_number=100 -> slots 7..5 emit F9, C0, C0;
- game_time=9 -> slots 2..0 emit FF, FF, 90.
REQ-033 Mid-conversion change: change step_number 12->99 during SHIFT of a step conversion -> that COMMIT writes 0/1/2; a later COMMIT writes 0/9/9 within 30 cycles.
REQ-034 Reset mid-operation: assert rst during SHIFT with display showing 237 -> on that edge all state matches REQ-026; after release, values reconvert from current inputs.
